// File: rtl/mode_select_pkg.sv
// Shared definitions for the user-mode selector: FSM state encoding and the guest mode value.
package mode_select_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      S_INIT   = 2'd0,
      S_IDLE   = 2'd1,
      S_DEB    = 2'd2,
      S_COMMIT = 2'd3
   } state_e;

   localparam int MODE_GUEST = 0;

endpackage

// File: rtl/mode_sync.sv
// Two-flop synchroniser for asynchronous board inputs; intentionally never reset.
module mode_sync #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   always_ff @(posedge clk) begin
      meta_q <= d;
      sync_q <= meta_q;
   end

   assign q = sync_q;

endmodule

// File: rtl/mode_select.sv
// User-mode selector: captures the switch mode during reset and, when MODE_SELECT_RESELECT_EN
// is defined, re-captures it at runtime on a debounced reselect with a req/ack handshake.
module mode_select
   import mode_select_pkg::*;
#(
   parameter int MODE_W     = 2,
   parameter int DEB_CYCLES = 4,
   parameter int ACK_TO     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [MODE_W-1:0] toggle,
   input  logic              reselect,
   input  logic              mode_ack,
   output logic [MODE_W-1:0] mode,
   output logic              flag,
   output logic              mode_valid,
   output logic              mode_req,
   output logic              ack_err
);

   logic [MODE_W-1:0] tog_s;
   logic              sel_s;

   mode_sync #(.W(MODE_W)) u_tog_sync (.clk(clk), .d(toggle),   .q(tog_s));
   mode_sync #(.W(1))      u_sel_sync (.clk(clk), .d(reselect), .q(sel_s));

   state_e            state_q, state_d;
   logic [MODE_W-1:0] mode_q,  mode_d;
   logic              flag_q,  flag_d;
   logic              valid_q, valid_d;

`ifdef MODE_SELECT_RESELECT_EN

   localparam int DEB_W = $clog2(DEB_CYCLES + 1);
   localparam int TO_W  = $clog2(ACK_TO + 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TO - 1);

   logic              req_q,      req_d;
   logic              err_q,      err_d;
   logic [DEB_W-1:0]  cnt_q,      cnt_d;
   logic [TO_W-1:0]   tcnt_q,     tcnt_d;
   logic [MODE_W-1:0] cand_q,     cand_d;
   logic              sel_prev_q, sel_prev_d;
   logic              rise_q,     rise_d;

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      valid_d    = valid_q;
      req_d      = req_q;
      err_d      = err_q;
      cnt_d      = cnt_q;
      tcnt_d     = tcnt_q;
      cand_d     = cand_q;
      sel_prev_d = sel_s;
      // registered edge pulse puts S_DEB entry three edges after the pin is first sampled
      rise_d     = sel_s & ~sel_prev_q;

      if (!rst) begin
         state_d = S_INIT;
         mode_d  = toggle;
         valid_d = 1'b0;
         req_d   = 1'b0;
         err_d   = 1'b0;
         cnt_d   = '0;
         tcnt_d  = '0;
         rise_d  = 1'b0;
      end else begin
         case (state_q)
            S_INIT: begin
               valid_d = 1'b1;
               state_d = S_IDLE;
            end
            S_IDLE: begin
               if (rise_q) begin
                  cnt_d   = '0;
                  cand_d  = tog_s;
                  valid_d = 1'b0;
                  state_d = S_DEB;
               end
            end
            S_DEB: begin
               if (tog_s != cand_q) begin
                  cand_d = tog_s;
                  cnt_d  = '0;
               end else if (cnt_q == DEB_LAST) begin
                  if (cand_q == mode_q) begin
                     valid_d = 1'b1;
                     state_d = S_IDLE;
                  end else begin
                     mode_d  = cand_q;
                     req_d   = 1'b1;
                     tcnt_d  = '0;
                     state_d = S_COMMIT;
                  end
               end else begin
                  cnt_d = cnt_q + DEB_W'(1);
               end
            end
            S_COMMIT: begin
               if (mode_ack || (tcnt_q == TO_LAST)) begin
                  req_d   = 1'b0;
                  valid_d = 1'b1;
                  state_d = S_IDLE;
                  if (!mode_ack) err_d = 1'b1;
               end else begin
                  tcnt_d = tcnt_q + TO_W'(1);
               end
            end
            default: state_d = S_INIT;
         endcase
      end

      flag_d = (mode_d != MODE_W'(MODE_GUEST));
   end

   always_ff @(posedge clk) begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      flag_q     <= flag_d;
      valid_q    <= valid_d;
      req_q      <= req_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      tcnt_q     <= tcnt_d;
      cand_q     <= cand_d;
      sel_prev_q <= sel_prev_d;
      rise_q     <= rise_d;
   end

   assign mode_req = req_q;
   assign ack_err  = err_q;

`else

   // legacy build: runtime reselect inputs and tuning parameters have no effect
   logic unused_inputs;
   assign unused_inputs = ^{tog_s, sel_s, mode_ack, 32'(DEB_CYCLES), 32'(ACK_TO)};

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      valid_d = valid_q;

      if (!rst) begin
         state_d = S_INIT;
         mode_d  = toggle;
         valid_d = 1'b0;
      end else begin
         case (state_q)
            S_INIT: begin
               valid_d = 1'b1;
               state_d = S_IDLE;
            end
            S_IDLE:  state_d = S_IDLE;
            default: state_d = S_INIT;
         endcase
      end

      flag_d = (mode_d != MODE_W'(MODE_GUEST));
   end

   always_ff @(posedge clk) begin
      state_q <= state_d;
      mode_q  <= mode_d;
      flag_q  <= flag_d;
      valid_q <= valid_d;
   end

   assign mode_req = 1'b0;
   assign ack_err  = 1'b0;

`endif

   assign mode       = mode_q;
   assign flag       = flag_q;
   assign mode_valid = valid_q;

endmodule

// File: tb/tb_mode_select.sv
// Directed bench for mode_select; reselect sequences are exercised when MODE_SELECT_RESELECT_EN is defined.
module tb_mode_select;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] toggle = 2'b00;
   logic       reselect = 1'b0;
   logic       mode_ack = 1'b0;
   logic [1:0] mode;
   logic       flag;
   logic       mode_valid;
   logic       mode_req;
   logic       ack_err;

   int total = 0;
   int bad   = 0;

   mode_select #(.MODE_W(2), .DEB_CYCLES(4), .ACK_TO(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .toggle     (toggle),
      .reselect   (reselect),
      .mode_ack   (mode_ack),
      .mode       (mode),
      .flag       (flag),
      .mode_valid (mode_valid),
      .mode_req   (mode_req),
      .ack_err    (ack_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] tog;
      logic [1:0] exp_mode;
      logic       exp_flag;
   } rst_vec_t;

   rst_vec_t vecs[4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // returns just after edge 0, the first edge that samples reselect high
   task automatic start_reselect();
      reselect = 1'b1;
      tick();
      reselect = 1'b0;
   endtask

   task automatic do_reset(input logic [1:0] tog);
      rst    = 1'b0;
      toggle = tog;
      tick();
      tick();
      rst = 1'b1;
      tick();
      tick();
   endtask

   initial begin
      vecs[0] = '{tog: 2'b00, exp_mode: 2'd0, exp_flag: 1'b0};
      vecs[1] = '{tog: 2'b01, exp_mode: 2'd1, exp_flag: 1'b1};
      vecs[2] = '{tog: 2'b11, exp_mode: 2'd3, exp_flag: 1'b1};
      vecs[3] = '{tog: 2'b10, exp_mode: 2'd2, exp_flag: 1'b1};

      // reset follows the raw switches every cycle
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         toggle = vecs[i].tog;
         tick();
         chk($sformatf("rst_mode[%0d]", i),  32'(mode),       32'(vecs[i].exp_mode));
         chk($sformatf("rst_flag[%0d]", i),  32'(flag),       32'(vecs[i].exp_flag));
         chk($sformatf("rst_valid[%0d]", i), 32'(mode_valid), 32'd0);
         chk($sformatf("rst_req[%0d]", i),   32'(mode_req),   32'd0);
         chk($sformatf("rst_err[%0d]", i),   32'(ack_err),    32'd0);
      end

      // release: the last reset edge is edge 1, valid rises at edge 2
      rst = 1'b1;
      chk("rel_valid_e1", 32'(mode_valid), 32'd0);
      tick();
      chk("rel_valid_e2", 32'(mode_valid), 32'd1);
      chk("rel_mode",     32'(mode),       32'd2);
      tick();

`ifdef MODE_SELECT_RESELECT_EN
      // basic reselect 0 -> 1 with ack tied high
      do_reset(2'b00);
      chk("b_mode0", 32'(mode), 32'd0);
      toggle   = 2'b01;
      mode_ack = 1'b1;
      tick(); tick(); tick();
      start_reselect();
      for (int e = 1; e <= 8; e++) begin
         tick();
         if (e == 2) chk("b_valid_e2", 32'(mode_valid), 32'd1);
         if (e == 3) chk("b_valid_e3", 32'(mode_valid), 32'd0);
         if (e == 6) chk("b_mode_e6",  32'(mode),       32'd0);
         if (e == 7) begin
            chk("b_mode_e7", 32'(mode),     32'd1);
            chk("b_req_e7",  32'(mode_req), 32'd1);
            chk("b_flag_e7", 32'(flag),     32'd1);
         end
         if (e == 8) begin
            chk("b_req_e8",   32'(mode_req),   32'd0);
            chk("b_valid_e8", 32'(mode_valid), 32'd1);
            chk("b_err_e8",   32'(ack_err),    32'd0);
         end
      end

      // bouncing switches: candidate restarts until four stable cycles
      tick(); tick();
      start_reselect();
      toggle = 2'b11;
      tick();
      toggle = 2'b01;
      tick();
      toggle = 2'b11;
      for (int e = 3; e <= 10; e++) begin
         tick();
         if (e == 8) chk("bn_mode_e8", 32'(mode), 32'd1);
         if (e == 9) begin
            chk("bn_mode_e9", 32'(mode),     32'd3);
            chk("bn_req_e9",  32'(mode_req), 32'd1);
         end
         if (e == 10) begin
            chk("bn_req_e10",   32'(mode_req),   32'd0);
            chk("bn_valid_e10", 32'(mode_valid), 32'd1);
         end
      end

      // reselect onto the current mode: no request
      tick(); tick();
      start_reselect();
      for (int e = 1; e <= 8; e++) begin
         tick();
         chk($sformatf("same_req_e%0d", e), 32'(mode_req), 32'd0);
         if (e == 6) chk("same_valid_e6", 32'(mode_valid), 32'd0);
         if (e == 7) chk("same_valid_e7", 32'(mode_valid), 32'd1);
      end
      chk("same_mode", 32'(mode), 32'd3);

      // ack never given: timeout after 16 request cycles, second reselect ignored
      mode_ack = 1'b0;
      toggle   = 2'b00;
      tick(); tick(); tick();
      start_reselect();
      for (int e = 1; e <= 30; e++) begin
         if (e == 10) reselect = 1'b1;
         if (e == 11) reselect = 1'b0;
         tick();
         if (e >= 7 && e <= 22) chk($sformatf("to_req_e%0d", e), 32'(mode_req), 32'd1);
         if (e == 7)  chk("to_mode_e7", 32'(mode), 32'd0);
         if (e == 22) chk("to_err_e22", 32'(ack_err), 32'd0);
         if (e >= 23) begin
            chk($sformatf("to_req_e%0d", e),   32'(mode_req),   32'd0);
            chk($sformatf("to_err_e%0d", e),   32'(ack_err),    32'd1);
            chk($sformatf("to_valid_e%0d", e), 32'(mode_valid), 32'd1);
         end
      end

      // reset in the middle of a pending request
      toggle = 2'b01;
      tick(); tick(); tick();
      start_reselect();
      for (int e = 1; e <= 9; e++) begin
         tick();
         if (e == 7) chk("ab_req_e7", 32'(mode_req), 32'd1);
      end
      rst    = 1'b0;
      toggle = 2'b10;
      tick();
      chk("ab_req",   32'(mode_req),   32'd0);
      chk("ab_err",   32'(ack_err),    32'd0);
      chk("ab_mode",  32'(mode),       32'd2);
      chk("ab_valid", 32'(mode_valid), 32'd0);
      rst = 1'b1;
      tick();
      chk("ab_valid_rel", 32'(mode_valid), 32'd1);
`else
      // legacy build: reselect and ack have no effect
      do_reset(2'b10);
      toggle   = 2'b01;
      mode_ack = 1'b1;
      tick(); tick(); tick();
      start_reselect();
      for (int e = 1; e <= 20; e++) begin
         if (e == 10) reselect = 1'b1;
         if (e == 11) reselect = 1'b0;
         tick();
         chk($sformatf("lg_mode_e%0d", e),  32'(mode),       32'd2);
         chk($sformatf("lg_valid_e%0d", e), 32'(mode_valid), 32'd1);
         chk($sformatf("lg_req_e%0d", e),   32'(mode_req),   32'd0);
         chk($sformatf("lg_err_e%0d", e),   32'(ack_err),    32'd0);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
